// File: rtl/mcmm_pkg.sv
// Shared definitions for the matrix-core / ALU sharing logic.
//   - DATA_W, OP_W : operand/result and opcode widths of the shared ALU
//   - OP_*         : ALU opcode encodings
//   - state_e      : arbiter FSM state encoding
package mcmm_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'd0;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd4;
  localparam logic [OP_W-1:0] OP_MOD  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker (purely combinational).
// Scans req_i starting at ptr_i and wrapping upward; the first set bit wins.
//   req_i    : per-core request vector
//   ptr_i    : index with highest priority this round
//   onehot_o : one-hot winner (all zero when no request)
//   idx_o    : binary winner index (0 when no request)
//   valid_o  : at least one request present
module rr_pick #(
  parameter int N_CORES = 4,
  parameter int IDX_W   = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_CORES-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int   pos;
  logic found;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    pos      = 0;
    for (int i = 0; i < N_CORES; i++) begin
      pos = (int'(ptr_i) + i) % N_CORES;
      if (!found && req_i[pos]) begin
        found         = 1'b1;
        idx_o         = IDX_W'(pos);
        onehot_o[pos] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among N_CORES requesters.
// Two-state FSM: IDLE picks a winner round-robin and latches its operands
// into the registers that drive the ALU; ISSUE captures the ALU output and
// returns it to the winner. One operation every two cycles.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req/req_op/req_ac/req_bus : per-core request level and packed operands
//   gnt, res_valid    : one-hot, single-cycle grant / result pulses
//   result, div_err   : returned data and divide-by-zero flag
//   busy              : high while in ISSUE
//   alu_bus/alu_ac/alu_op : registered ALU inputs
//   alu_out           : ALU data output
module alu_share_arbiter #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES*OP_W-1:0]   req_op,
  input  logic [N_CORES*DATA_W-1:0] req_ac,
  input  logic [N_CORES*DATA_W-1:0] req_bus,
  output logic [N_CORES-1:0]        gnt,
  output logic [N_CORES-1:0]        res_valid,
  output logic [DATA_W-1:0]         result,
  output logic                      div_err,
  output logic                      busy,
  output logic [DATA_W-1:0]         alu_bus,
  output logic [DATA_W-1:0]         alu_ac,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_out
);

  import mcmm_pkg::*;

  localparam int IDX_W = $clog2(N_CORES);

  state_e               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     win_idx_q;
  logic                 dz_q;
  logic [N_CORES-1:0]   gnt_q;
  logic [N_CORES-1:0]   res_valid_q;
  logic [DATA_W-1:0]    result_q;
  logic                 div_err_q;
  logic                 busy_q;
  logic [DATA_W-1:0]    alu_bus_q;
  logic [DATA_W-1:0]    alu_ac_q;
  logic [OP_W-1:0]      alu_op_q;

  logic [N_CORES-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic [OP_W-1:0]      op_d;
  logic [DATA_W-1:0]    ac_d;
  logic [DATA_W-1:0]    bus_d;
  logic                 dz_d;

  rr_pick #(
    .N_CORES (N_CORES),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Winner's operands; a div/mod by zero is turned into a pass so the ALU
  // never sees a zero divisor, and the result is substituted at capture.
  always_comb begin
    op_d  = req_op [pick_idx*OP_W   +: OP_W];
    ac_d  = req_ac [pick_idx*DATA_W +: DATA_W];
    bus_d = req_bus[pick_idx*DATA_W +: DATA_W];
    dz_d  = ((op_d == OP_DIV) || (op_d == OP_MOD)) && (bus_d == '0);
  end

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      win_idx_q   <= '0;
      dz_q        <= 1'b0;
      gnt_q       <= '0;
      res_valid_q <= '0;
      result_q    <= '0;
      div_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      alu_bus_q   <= '0;
      alu_ac_q    <= '0;
      alu_op_q    <= OP_PASS;
    end else begin
      // Pulses last one cycle unless re-asserted below.
      gnt_q       <= '0;
      res_valid_q <= '0;
      div_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            alu_op_q  <= dz_d ? OP_PASS : op_d;
            alu_ac_q  <= ac_d;
            alu_bus_q <= bus_d;
            dz_q      <= dz_d;
            win_idx_q <= pick_idx;
            gnt_q     <= pick_onehot;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          result_q    <= dz_q ? '1 : alu_out;
          div_err_q   <= dz_q;
          res_valid_q <= N_CORES'(1) << win_idx_q;
          rr_ptr_q    <= (win_idx_q == IDX_W'(N_CORES - 1)) ? '0
                                                             : win_idx_q + IDX_W'(1);
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign div_err   = div_err_q;
  assign busy      = busy_q;
  assign alu_bus   = alu_bus_q;
  assign alu_ac    = alu_ac_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the
// shared ALU on the alu_* ports. Inputs driven and outputs sampled on the
// falling clock edge.
module tb_alu_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_ac;
  logic [N*DW-1:0] req_bus;
  logic [N-1:0]    gnt;
  logic [N-1:0]    res_valid;
  logic [DW-1:0]   result;
  logic            div_err;
  logic            busy;
  logic [DW-1:0]   alu_bus;
  logic [DW-1:0]   alu_ac;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_CORES(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_op    (req_op),
    .req_ac    (req_ac),
    .req_bus   (req_bus),
    .gnt       (gnt),
    .res_valid (res_valid),
    .result    (result),
    .div_err   (div_err),
    .busy      (busy),
    .alu_bus   (alu_bus),
    .alu_ac    (alu_ac),
    .alu_op    (alu_op),
    .alu_out   (alu_out)
  );

  // Shared ALU model: pass forwards in_bus; opcodes 6,7 behave as pass.
  logic [31:0] prod;
  always_comb begin
    prod    = {16'h0, alu_ac} * {16'h0, alu_bus};
    alu_out = alu_bus;
    case (alu_op)
      3'd1: alu_out = prod[15:0];
      3'd2: alu_out = alu_ac + alu_bus;
      3'd3: alu_out = alu_ac - alu_bus;
      3'd4: alu_out = (alu_bus != 16'h0) ? alu_ac / alu_bus : 16'h0;
      3'd5: alu_out = (alu_bus != 16'h0) ? alu_ac % alu_bus : 16'h0;
      default: alu_out = alu_bus;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_core(input int c, input logic [2:0] op, input logic [15:0] ac,
                          input logic [15:0] bus);
    req_op [c*OW +: OW] = op;
    req_ac [c*DW +: DW] = ac;
    req_bus[c*DW +: DW] = bus;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},       32'(gnt),       32'h0);
    check({tag, " res_valid"}, 32'(res_valid), 32'h0);
    check({tag, " result"},    32'(result),    32'h0);
    check({tag, " div_err"},   32'(div_err),   32'h0);
    check({tag, " busy"},      32'(busy),      32'h0);
    check({tag, " alu_bus"},   32'(alu_bus),   32'h0);
    check({tag, " alu_ac"},    32'(alu_ac),    32'h0);
    check({tag, " alu_op"},    32'(alu_op),    32'h0);
  endtask

  // One single-core transaction; called just after a falling edge in IDLE.
  task automatic do_op(input string tag, input int c, input logic [2:0] op,
                       input logic [15:0] ac, input logic [15:0] bus,
                       input logic [2:0] exp_alu_op, input logic [15:0] exp_res,
                       input logic exp_err);
    set_core(c, op, ac, bus);
    req = 4'b0001 << c;
    @(posedge clk); @(negedge clk);
    check({tag, " gnt"},    32'(gnt),    32'(4'b0001 << c));
    check({tag, " busy"},   32'(busy),   32'h1);
    check({tag, " alu_op"}, 32'(alu_op), 32'(exp_alu_op));
    check({tag, " alu_ac"}, 32'(alu_ac), 32'(ac));
    req = '0;
    @(posedge clk); @(negedge clk);
    check({tag, " res_valid"}, 32'(res_valid), 32'(4'b0001 << c));
    check({tag, " result"},    32'(result),    32'(exp_res));
    check({tag, " div_err"},   32'(div_err),   32'(exp_err));
    check({tag, " gnt_off"},   32'(gnt),       32'h0);
  endtask

  int          order [5] = '{0, 1, 2, 3, 0};
  logic [15:0] sums  [4] = '{16'd101, 16'd112, 16'd123, 16'd134};

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_ac = '0; req_bus = '0;
    #1;
    check_all_zero("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Idle with no requests.
    repeat (4) begin
      @(negedge clk);
      check("idle gnt",  32'(gnt),  32'h0);
      check("idle busy", 32'(busy), 32'h0);
    end

    // All four cores requesting add: rotation 0,1,2,3,0 (ptr wraps 3->0).
    for (int c = 0; c < N; c++) set_core(c, 3'd2, 16'(c*10 + 1), 16'(c + 100));
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check("rr gnt",  32'(gnt),  32'(4'b0001 << order[k]));
      check("rr busy", 32'(busy), 32'h1);
      if (k == 4) req = '0;
      @(posedge clk); @(negedge clk);
      check("rr res_valid", 32'(res_valid), 32'(4'b0001 << order[k]));
      check("rr result",    32'(result),    32'(sums[order[k]]));
      check("rr gnt_off",   32'(gnt),       32'h0);
    end
    @(negedge clk);
    check("rr drained gnt", 32'(gnt), 32'h0);

    // Directed single-core operations.
    do_op("mul",      1, 3'd1, 16'd7,   16'd6,      3'd1, 16'd42,    1'b0);
    do_op("mul_wrap", 1, 3'd1, 16'd300, 16'd300,    3'd1, 16'd24464, 1'b0);
    do_op("div",      2, 3'd4, 16'd17,  16'd5,      3'd4, 16'd3,     1'b0);
    do_op("mod",      2, 3'd5, 16'd17,  16'd5,      3'd5, 16'd2,     1'b0);
    do_op("sub",      2, 3'd3, 16'd3,   16'd5,      3'd3, 16'hFFFE,  1'b0);
    do_op("div0",     0, 3'd4, 16'd9,   16'd0,      3'd0, 16'hFFFF,  1'b1);
    do_op("mod0",     1, 3'd5, 16'd9,   16'd0,      3'd0, 16'hFFFF,  1'b1);
    do_op("op6",      0, 3'd6, 16'd9,   16'h1234,   3'd6, 16'h1234,  1'b0);

    // Reset during ISSUE: operation aborted, outputs cleared immediately.
    set_core(3, 3'd2, 16'd1, 16'd1);
    req = 4'b1000;
    @(posedge clk); @(negedge clk);
    check("abort gnt", 32'(gnt), 32'h8);
    req = '0;
    #1 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); @(negedge clk);
    check("abort res_valid", 32'(res_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst res_valid", 32'(res_valid), 32'h0);

    // Pointer back at 0: core0 beats core3.
    set_core(0, 3'd2, 16'd5,   16'd6);
    set_core(3, 3'd2, 16'd100, 16'd100);
    req = 4'b1001;
    @(posedge clk); @(negedge clk);
    check("post_rst gnt", 32'(gnt), 32'h1);
    req = '0;
    @(posedge clk); @(negedge clk);
    check("post_rst res", 32'(res_valid), 32'h1);
    check("post_rst result", 32'(result), 32'd11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
